// File: rtl/ihp_sram_clear_sequencer.sv
// ihp_sram_clear_sequencer: owns the IHP SRAM macro after reset and sweeps
// every word to CLEAR_VALUE. It then hands the port to the fabric as a
// transparent pass-through. A re-clear can be requested while in pass-through.
module ihp_sram_clear_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  input  logic                  CONFIGURED_top,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  fabric_ready,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_SRAM,
  input  logic [DATA_WIDTH-1:0] A_DIN_SRAM,
  input  logic [DATA_WIDTH-1:0] A_BM_SRAM,
  input  logic                  A_WEN_SRAM,
  input  logic                  A_MEN_SRAM,
  input  logic                  A_REN_SRAM,
  output logic [DATA_WIDTH-1:0] A_DOUT_SRAM,
  output logic [ADDR_WIDTH-1:0] M_ADDR,
  output logic [DATA_WIDTH-1:0] M_DIN,
  output logic [DATA_WIDTH-1:0] M_BM,
  output logic                  M_WEN,
  output logic                  M_MEN,
  output logic                  M_REN,
  input  logic [DATA_WIDTH-1:0] M_DOUT
);

  // One extra counter bit flags the end of the sweep without relying on wrap.
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PASS  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic             done_q, done_d;
  logic             rd_own_q, rd_own_d;

  // Configuration status only informs software; it never gates the sweep.
  logic unused_cfg;
  assign unused_cfg = CONFIGURED_top;

  // Next-state logic for the sweep FSM, done flag and read ownership.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    done_d   = done_q;
    rd_own_d = (state_q == ST_PASS) && A_MEN_SRAM && A_REN_SRAM;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_CLEAR;
        sweep_d = '0;
      end
      ST_CLEAR: begin
        sweep_d = sweep_q + CNT_W'(1);
        if (sweep_d[ADDR_WIDTH]) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
        end
      end
      ST_PASS: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sweep_d = '0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      sweep_q  <= '0;
      done_q   <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      done_q   <= done_d;
      rd_own_q <= rd_own_d;
    end
  end

  // Macro port mux: disabled in IDLE, sweep writes in CLEAR, fabric in PASS.
  always_comb begin
    M_ADDR = '0;
    M_DIN  = '0;
    M_BM   = '0;
    M_WEN  = 1'b0;
    M_MEN  = 1'b0;
    M_REN  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        M_ADDR = sweep_q[ADDR_WIDTH-1:0];
        M_DIN  = CLEAR_VALUE;
        M_BM   = '1;
        M_WEN  = 1'b1;
        M_MEN  = 1'b1;
      end
      ST_PASS: begin
        M_ADDR = A_ADDR_SRAM;
        M_DIN  = A_DIN_SRAM;
        M_BM   = A_BM_SRAM;
        M_WEN  = A_WEN_SRAM;
        M_MEN  = A_MEN_SRAM;
        M_REN  = A_REN_SRAM;
      end
      default: ;
    endcase
  end

  // Only data from a fabric-issued read reaches the fabric.
  assign A_DOUT_SRAM  = rd_own_q ? M_DOUT : '0;
  assign clear_busy   = (state_q != ST_PASS);
  assign fabric_ready = (state_q == ST_PASS);
  assign clear_done   = done_q;

endmodule

// File: tb/tb_ihp_sram_clear_sequencer.sv
// Self-checking bench: randomized fabric traffic against a behavioural model
// of the sweep (position counter + shadow memory) and a 1-cycle macro model.
module tb_ihp_sram_clear_sequencer;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg;
  logic          clear_req;
  logic          clear_busy, clear_done, fabric_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din, a_bm, a_dout;
  logic          a_wen, a_men, a_ren;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_bm, m_dout;
  logic          m_wen, m_men, m_ren;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ihp_sram_clear_sequencer dut (
    .UserCLK(clk), .resetn(resetn), .CONFIGURED_top(cfg), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done), .fabric_ready(fabric_ready),
    .A_ADDR_SRAM(a_addr), .A_DIN_SRAM(a_din), .A_BM_SRAM(a_bm),
    .A_WEN_SRAM(a_wen), .A_MEN_SRAM(a_men), .A_REN_SRAM(a_ren),
    .A_DOUT_SRAM(a_dout),
    .M_ADDR(m_addr), .M_DIN(m_din), .M_BM(m_bm),
    .M_WEN(m_wen), .M_MEN(m_men), .M_REN(m_ren), .M_DOUT(m_dout)
  );

  // Macro model: random power-up contents, 1-cycle read latency, bit-masked writes.
  logic [DW-1:0] mac_mem [DEPTH];
  logic [DW-1:0] mac_dout;
  logic          force_dout;
  logic          c_men, c_wen, c_ren;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_din, c_bm;
  assign m_dout = force_dout ? 32'hCAFEF00D : mac_dout;

  initial begin
    for (int i = 0; i < DEPTH; i++) mac_mem[i] = $urandom;
    mac_dout = 32'h1234_5678;
    forever begin
      @(negedge clk);
      #3;
      c_men  = resetn && m_men;
      c_wen  = m_wen;
      c_ren  = m_ren;
      c_addr = m_addr;
      c_din  = m_din;
      c_bm   = m_bm;
      @(posedge clk);
      if (resetn && c_men) begin
        if (c_ren) mac_dout <= mac_mem[c_addr];
        if (c_wen) mac_mem[c_addr] <= (mac_mem[c_addr] & ~c_bm) | (c_din & c_bm);
      end
    end
  end

  // Behavioural model: pos<0 before the sweep, 0..DEPTH-1 = word being
  // cleared this cycle, DEPTH = fabric owns the port.
  int            pos;
  logic          m_done;
  logic [DW-1:0] exp_dout;
  logic [DW-1:0] ref_mem [DEPTH];
  int            edge_cnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos      <= -1;
      m_done   <= 1'b0;
      exp_dout <= '0;
    end else begin
      exp_dout <= '0;
      if (pos < 0) begin
        pos <= 0;
      end else if (pos < DEPTH) begin
        ref_mem[pos[AW-1:0]] <= '0;
        pos <= pos + 1;
        if (pos == DEPTH - 1) m_done <= 1'b1;
      end else begin
        if (a_men && a_ren) exp_dout <= ref_mem[a_addr];
        if (a_men && a_wen) ref_mem[a_addr] <= (ref_mem[a_addr] & ~a_bm) | (a_din & a_bm);
        if (clear_req) begin
          pos    <= 0;
          m_done <= 1'b0;
        end
      end
    end
  end

  // Edges since reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    logic [76:0] exp_drv, act_drv;
    logic [2:0]  exp_st;
    if (pos < 0) begin
      exp_drv = '0;
    end else if (pos < DEPTH) begin
      exp_drv = {1'b1, 1'b1, 1'b0, pos[AW-1:0], {DW{1'b0}}, {DW{1'b1}}};
    end else begin
      exp_drv = {a_men, a_wen, a_ren, a_addr, a_din, a_bm};
    end
    act_drv = {m_men, m_wen, m_ren, m_addr, m_din, m_bm};
    exp_st  = {(pos != DEPTH), (pos == DEPTH), m_done};
    chk("macro_drive", 128'(act_drv), 128'(exp_drv));
    chk("status", 128'({clear_busy, fabric_ready, clear_done}), 128'(exp_st));
    chk("a_dout", 128'(a_dout), 128'(exp_dout));
  endtask

  task automatic settle();
    #2;
    compare();
  endtask

  task automatic idle_in();
    a_men = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
    a_addr = '0; a_din = '0; a_bm = '0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [DW-1:0] bm);
    @(negedge clk);
    a_men = 1'b1; a_wen = 1'b1; a_ren = 1'b0; a_addr = ad; a_din = d; a_bm = bm;
    settle();
    @(negedge clk);
    idle_in();
    settle();
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] ad, input logic [DW-1:0] exp);
    @(negedge clk);
    a_men = 1'b1; a_wen = 1'b0; a_ren = 1'b1; a_addr = ad;
    settle();
    @(negedge clk);
    idle_in();
    settle();
    chk(nm, 128'(a_dout), 128'(exp));
  endtask

  // Follow one sweep to PASS; mode 0 = blocked fabric writes, 1 = re-clear
  // with read gating and an ignored mid-sweep request, 2 = plain.
  task automatic sweep_check(input string nm, input int t0, input int exp_edges, input int mode);
    int wrs  = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (mode == 0) begin
        if (clear_busy) begin
          a_men = 1'b1; a_wen = 1'b1; a_addr = 10'd5; a_din = 32'hDEADBEEF; a_bm = '1;
        end else begin
          idle_in();
        end
        if (i == 100) cfg = 1'b1;
      end
      if (mode == 1 && i == 0)   idle_in();
      if (mode == 1 && i == 500) clear_req = 1'b1;
      if (mode == 1 && i == 501) clear_req = 1'b0;
      settle();
      if (clear_busy && m_men && m_wen) wrs++;
      if (mode == 1 && i == 0) begin
        chk("gate_accept_rd", 128'(a_dout), 128'(32'h0000A5A5));
        chk("reclr_done_low", 128'(clear_done), 128'(1'b0));
        @(posedge clk);
        #1 force_dout = 1'b1;
      end
      if (mode == 1 && i == 1) begin
        chk("gate_clear_dout", 128'(a_dout), 128'(32'h0));
        chk("gate_forced_mdout", 128'(m_dout), 128'(32'hCAFEF00D));
        force_dout = 1'b0;
      end
      if (fabric_ready) seen = 1'b1;
    end
    chk({nm, "_edges"}, 128'(edge_cnt - t0), 128'(exp_edges));
    chk({nm, "_writes"}, 128'(wrs), 128'(1024));
    chk({nm, "_done"}, 128'(clear_done), 128'(1'b1));
  endtask

  initial begin
    resetn = 1'b0; cfg = 1'b0; force_dout = 1'b0;
    idle_in();
    repeat (3) begin
      @(negedge clk);
      settle();
    end
    chk("rst_status", 128'({clear_busy, fabric_ready, clear_done}), 128'(3'b100));
    chk("rst_macro", 128'({m_men, m_wen, m_ren, m_addr}), 128'(0));
    chk("rst_dout", 128'(a_dout), 128'(0));
    @(posedge clk);
    #1 resetn = 1'b1;

    sweep_check("pwr", 0, 1025, 0);
    rd("blocked_rd5", 10'd5, 32'h0);
    wr(10'h3FF, 32'hA5A5A5A5, 32'h0000FFFF);
    rd("pt_rw", 10'h3FF, 32'h0000A5A5);

    @(negedge clk);
    clear_req = 1'b1; a_men = 1'b1; a_ren = 1'b1; a_addr = 10'h3FF;
    settle();
    sweep_check("reclr", edge_cnt + 1, 1024, 1);
    rd("reclr_rd", 10'h3FF, 32'h0);

    // Reset in the middle of a sweep.
    @(negedge clk);
    clear_req = 1'b1;
    settle();
    @(negedge clk);
    clear_req = 1'b0;
    settle();
    for (int i = 0; i < 400 && pos != 300; i++) begin
      @(negedge clk);
      settle();
    end
    chk("mid_addr", 128'(m_addr), 128'(300));
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_men", 128'({m_men, m_wen, m_addr}), 128'(0));
    chk("mid_rst_status", 128'({clear_busy, fabric_ready, clear_done}), 128'(3'b100));
    repeat (3) begin
      @(negedge clk);
      settle();
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    sweep_check("rst_sweep", 0, 1025, 2);

    // Random fabric traffic with occasional re-clear requests.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a_men  = 1'($urandom_range(0, 3) != 0);
      a_wen  = 1'($urandom_range(0, 1));
      a_ren  = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a_addr = a_addr | 10'h3F0;
      a_din  = $urandom;
      a_bm   = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
      clear_req = 1'($urandom_range(0, 499) == 0);
      cfg    = 1'($urandom_range(0, 1));
      settle();
    end
    @(negedge clk);
    idle_in();
    settle();
    for (int i = 0; i < 1100 && !fabric_ready; i++) begin
      @(negedge clk);
      settle();
    end
    chk("final_ready", 128'(fabric_ready), 128'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
